mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter BASE, default 32'h8000_0000, first byte address served.
REQ-002 SHALL have parameter WORDS, default 4096, memory size in 32-bit words, power of two.
REQ-003 SHALL have parameter LATENCY, default 2, cycles from request accept to response enqueue, range 1..8.
REQ-004 SHALL have parameter QUEUE_DEPTH, default 2, maximum outstanding requests, range 1..8.
REQ-005 SHALL have parameter INIT_FILE, default "", hex image loaded at elaboration when non-empty.
REQ-006 SHALL have port clk, input, 1, single clock; all state samples on the rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port req, decoupled.in, data 32, byte address from the CPU-side arbiter.
REQ-009 SHALL have port resp, decoupled.out, data 32, read word returned in request order.
REQ-010 SHALL have port bd_we, input, 1, backdoor write enable for preloading.
REQ-011 SHALL have port bd_addr, input, 32, backdoor byte address.
REQ-012 SHALL have port bd_data, input, 32, backdoor write word.

Function
REQ-013 SHALL accept a request when req.valid && req.ready; req.ready = (outstanding < QUEUE_DEPTH).
REQ-014 SHALL compute outstanding as in-pipeline entries plus response-queue entries; it increments on accept, decrements on resp fire, and is unchanged when both occur in the same cycle.
REQ-015 SHALL index the memory with word = (addr - BASE) >> 2, truncated to log2(WORDS) bits.
REQ-016 SHALL read the memory in the accept cycle, so the data is the pre-write value if bd_we targets the same word in that cycle.
REQ-017 SHALL carry accepted data through a LATENCY-stage valid/data shift pipeline, then enqueue it into a QUEUE_DEPTH-entry FIFO.
REQ-018 SHALL drive resp.valid when the FIFO is non-empty and present the FIFO head on resp.data.
REQ-019 SHALL give minimum accept-to-resp.valid latency of exactly LATENCY cycles when the FIFO is empty.
REQ-020 SHALL hold resp.data stable while resp.valid && !resp.ready.
REQ-021 SHALL never overflow the FIFO; credit accounting per REQ-013 guarantees this, and a bench assertion checks it.
REQ-022 SHALL sustain one accept per cycle at continuous resp.ready when QUEUE_DEPTH >= LATENCY + 1; otherwise throughput is limited to QUEUE_DEPTH per LATENCY+1 cycles.
REQ-023 SHALL write bd_data into the word at bd_addr (per REQ-015) on any cycle with bd_we, independent of the req/resp handshakes.
REQ-024 SHALL ignore addr[1:0] when the REQ-029 macro is undefined.

Reset
REQ-025 SHALL, on rst assertion, immediately clear the pipeline valids, FIFO pointers and outstanding count.
REQ-026 SHALL hold resp.valid=0 and req.ready=1 (QUEUE_DEPTH >= 1) during and directly after reset.
REQ-027 SHALL discard requests in flight when reset occurs mid-operation, producing no response for them after release.
REQ-028 SHALL leave memory contents unaffected by reset.

Configuration
REQ-029 SHALL, with MEM_RESPONDER_RANGE_CHECK_EN defined, return 32'hDEAD_BEEF and pulse output bad_addr for one cycle at the accept edge for any request that is misaligned, below BASE, or at or above BASE + 4*WORDS; ordering and latency are unchanged.
REQ-030 SHALL, without MEM_RESPONDER_RANGE_CHECK_EN, omit bad_addr and wrap all addresses modulo WORDS per REQ-015.

Verification
REQ-031 Bench SHALL cover: backdoor write word 0 = 32'h0000_0013, then req 32'h8000_0000 at cycle t -> resp.valid at t+2 with data 32'h0000_0013.
REQ-032 Bench SHALL cover: resp.ready=0, three back-to-back reqs at QUEUE_DEPTH=2 -> the third stalls (req.ready=0) until the first resp fires; responses arrive in order.
REQ-033 Bench SHALL cover: QUEUE_DEPTH=3, LATENCY=2, resp.ready=1, 10 streaming reqs -> 10 responses on 10 consecutive cycles.
REQ-034 Bench SHALL cover: bd_we to word 5 in the same cycle as a req for word 5 -> old value returned; a following req returns the new value.
REQ-035 Bench SHALL cover: rst pulsed one cycle after an accept -> no response emerges; resp.valid=0 and req.ready=1 after release.
REQ-036 Bench SHALL cover: with the macro, req 32'h7FFF_FFFC -> 32'hDEAD_BEEF and a bad_addr pulse; without the macro, same addr -> word WORDS-1.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between the CPU-side arbiter (master)
// and the memory responder (slave). Both channels are valid/ready decoupled.
interface mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  modport slave (
    input  req_valid, req_data, resp_ready,
    output req_ready, resp_valid, resp_data
  );

  modport master (
    output req_valid, req_data, resp_ready,
    input  req_ready, resp_valid, resp_data
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word-read memory responder with in-order response FIFO,
// credit-based request flow control and a backdoor write port for preloading.
// Optional feature: define MEM_RESPONDER_RANGE_CHECK_EN to flag misaligned or
// out-of-window requests (bad_addr_o pulse, data 32'hDEAD_BEEF); without it,
// addr[1:0] is ignored and addresses wrap modulo WORDS.
module mem_responder #(
  parameter logic [31:0] BASE        = 32'h8000_0000,
  parameter int          WORDS       = 4096,
  parameter int          LATENCY     = 2,
  parameter int          QUEUE_DEPTH = 2,
  parameter              INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_responder_if.slave        bus,
  input  logic                  bd_we_i,
  input  logic [31:0]           bd_addr_i,
  input  logic [31:0]           bd_data_i
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  ,
  output logic                  bad_addr_o
`endif
);

  localparam int AW = $clog2(WORDS);
  localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CW = $clog2(QUEUE_DEPTH + 1);

  // Byte address to word index relative to BASE, wrapping modulo WORDS.
  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE) >> 2);
  endfunction

  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
    return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  // 33-bit offset so that addresses below BASE show up as a borrow.
  function automatic logic out_of_range(input logic [31:0] a);
    logic [32:0] off;
    off = {1'b0, a} - {1'b0, BASE};
    return (a[1:0] != 2'b00) || off[32] || (off[31:0] >= 32'(4 * WORDS));
  endfunction
`endif

  logic [31:0] mem_q [WORDS];

  // Backdoor write port, independent of the request/response handshakes.
  always @(posedge clk) begin
    if (bd_we_i) mem_q[word_idx(bd_addr_i)] <= bd_data_i;
  end

  logic        acc;
  logic        deq;
  logic [31:0] rd_data;
  logic        enq_vld;
  logic [31:0] enq_data;

  assign acc = bus.req_valid && bus.req_ready;
  assign deq = bus.resp_valid && bus.resp_ready;

  // Asynchronous read in the accept cycle: a same-cycle backdoor write to
  // the same word lands at the clock edge, so the old value is captured.
  always_comb begin
    rd_data = mem_q[word_idx(bus.req_data)];
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    if (out_of_range(bus.req_data)) rd_data = 32'hDEAD_BEEF;
`endif
  end

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  assign bad_addr_o = acc && out_of_range(bus.req_data);
`endif

  // The accept cycle itself is the first latency stage, so LATENCY-1
  // register stages sit between the read and the FIFO write.
  generate
    if (LATENCY == 1) begin : g_nopipe
      assign enq_vld  = acc;
      assign enq_data = rd_data;
    end else begin : g_pipe
      logic [LATENCY-2:0] vld_q;
      logic [31:0]        dat_q [LATENCY-1];

      // Valid shift chain; cleared on reset so in-flight reads are dropped.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q <= '0;
        end else begin
          vld_q[0] <= acc;
          for (int i = 1; i < LATENCY - 1; i++) vld_q[i] <= vld_q[i-1];
        end
      end

      // Data shift chain, qualified by vld_q and therefore not reset.
      always_ff @(posedge clk) begin
        dat_q[0] <= rd_data;
        for (int i = 1; i < LATENCY - 1; i++) dat_q[i] <= dat_q[i-1];
      end

      assign enq_vld  = vld_q[LATENCY-2];
      assign enq_data = dat_q[LATENCY-2];
    end
  endgenerate

  logic [31:0]   fifo_q [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fcnt_q, fcnt_d, osd_q, osd_d;

  // Outstanding credits cover both pipeline and FIFO, so the FIFO can
  // never be written while full.
  assign bus.req_ready  = (osd_q < CW'(QUEUE_DEPTH));
  assign bus.resp_valid = (fcnt_q != '0);
  assign bus.resp_data  = fifo_q[rd_ptr_q];

  // Next-state for FIFO pointers, FIFO occupancy and outstanding count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    osd_d    = osd_q;
    if (enq_vld) wr_ptr_d = nxt_ptr(wr_ptr_q);
    if (deq)     rd_ptr_d = nxt_ptr(rd_ptr_q);
    case ({enq_vld, deq})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
    case ({acc, deq})
      2'b10:   osd_d = osd_q + 1'b1;
      2'b01:   osd_d = osd_q - 1'b1;
      default: osd_d = osd_q;
    endcase
  end

  // Control state register with immediate clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      osd_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      osd_q    <= osd_d;
    end
  end

  // FIFO storage; the head entry is untouched until it is dequeued.
  always_ff @(posedge clk) begin
    if (enq_vld) fifo_q[wr_ptr_q] <= enq_data;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (QUEUE_DEPTH 2 and 3, LATENCY 2)
// sharing clock, reset and backdoor port; a queue-level reference model is
// compared against both every cycle, plus directed literal expectations.
module tb_mem_responder;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          WORDS = 4096;
  localparam int          LAT   = 2;
  localparam int          QDA   = 2;
  localparam int          QDB   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bd_we = 1'b0;
  logic [31:0] bd_addr = '0;
  logic [31:0] bd_data = '0;
  int          nvec = 0;
  int          nerr = 0;
  int          cyc = 0;

  mem_responder_if ifa();
  mem_responder_if ifb();

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
  logic bad_a, bad_b;
`endif

  mem_responder #(.BASE(BASE), .WORDS(WORDS), .LATENCY(LAT), .QUEUE_DEPTH(QDA)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa),
    .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_data_i(bd_data)
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    , .bad_addr_o(bad_a)
`endif
  );

  mem_responder #(.BASE(BASE), .WORDS(WORDS), .LATENCY(LAT), .QUEUE_DEPTH(QDB)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb),
    .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_data_i(bd_data)
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    , .bad_addr_o(bad_b)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] sh [WORDS];
  logic [31:0] md  [2][16];
  int          mav [2][16];
  int          mhd [2];
  int          mtl [2];
  int          mcnt[2];

  function automatic int widx(input logic [31:0] a);
    return int'(((a - BASE) >> 2) % 32'(WORDS));
  endfunction

  function automatic logic is_bad(input logic [31:0] a);
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    return (a[1:0] != 2'b00) || (a < BASE) || ((a - BASE) >= 32'(4 * WORDS));
`else
    return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (is_bad(a)) return 32'hDEAD_BEEF;
    return sh[widx(a)];
  endfunction

  task automatic model_step(input int k, input int qd, input string tag,
                            input logic rv, input logic [31:0] rd, input logic rr,
                            input logic pv, input logic pr, input logic [31:0] pa);
    logic ev;
    ev = 1'b0;
    if (rst) begin
      mhd[k] = 0; mtl[k] = 0; mcnt[k] = 0;
      chk({tag, "_rst_resp_valid"}, 32'(rv), 32'd0);
      chk({tag, "_rst_req_ready"}, 32'(pr), 32'd1);
      return;
    end
    if (mcnt[k] > 0) ev = (mav[k][mhd[k]] <= cyc);
    chk({tag, "_resp_valid"}, 32'(rv), 32'(ev));
    if (ev) chk({tag, "_resp_data"}, rd, md[k][mhd[k]]);
    chk({tag, "_req_ready"}, 32'(pr), 32'(mcnt[k] < qd));
    if (ev && rr) begin
      mhd[k] = (mhd[k] + 1) % 16;
      mcnt[k]--;
    end
    if (pv && pr) begin
      md[k][mtl[k]]  = model_read(pa);
      mav[k][mtl[k]] = cyc + LAT;
      mtl[k] = (mtl[k] + 1) % 16;
      mcnt[k]++;
    end
    chk({tag, "_no_overflow"}, 32'(mcnt[k] <= qd), 32'd1);
  endtask

  always @(negedge clk) begin
    model_step(0, QDA, "a", ifa.resp_valid, ifa.resp_data, ifa.resp_ready,
               ifa.req_valid, ifa.req_ready, ifa.req_data);
    model_step(1, QDB, "b", ifb.resp_valid, ifb.resp_data, ifb.resp_ready,
               ifb.req_valid, ifb.req_ready, ifb.req_data);
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    chk("a_bad_addr", 32'(bad_a),
        32'(!rst && ifa.req_valid && ifa.req_ready && is_bad(ifa.req_data)));
    chk("b_bad_addr", 32'(bad_b),
        32'(!rst && ifb.req_valid && ifb.req_ready && is_bad(ifb.req_data)));
`endif
    if (bd_we) sh[widx(bd_addr)] = bd_data;
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bd_write(input logic [31:0] a, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    step();
    bd_we = 1'b0;
  endtask

  task automatic wait_resp_a(input string nm, input logic [31:0] exp);
    int n;
    n = 0;
    while (!ifa.resp_valid && n < 20) begin
      step();
      n++;
    end
    if (!ifa.resp_valid) begin
      nvec++; nerr++;
      $display("FAIL %s: no response within 20 cycles, expected %h", nm, exp);
    end else begin
      chk(nm, ifa.resp_data, exp);
    end
    step();
  endtask

  function automatic logic [31:0] wa(input int i);
    return BASE + 32'(4 * i);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int nf, first, last;
    logic [31:0] t6_addr [3];
    logic [31:0] t6_exp  [3];
    ifa.req_valid = 1'b0; ifa.req_data = '0; ifa.resp_ready = 1'b1;
    ifb.req_valid = 1'b0; ifb.req_data = '0; ifb.resp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin mhd[i] = 0; mtl[i] = 0; mcnt[i] = 0; end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_resp_valid", 32'(ifa.resp_valid), 32'd0);
    chk("rst_req_ready", 32'(ifa.req_ready), 32'd1);
    rst = 1'b0;
    step();
    chk("post_rst_resp_valid", 32'(ifa.resp_valid), 32'd0);
    chk("post_rst_req_ready", 32'(ifa.req_ready), 32'd1);

    // Backdoor word 0, read it back with latency 2
    bd_write(BASE, 32'h0000_0013);
    ifa.req_valid = 1'b1; ifa.req_data = BASE;
    step();
    ifa.req_valid = 1'b0;
    chk("t1_valid_t_plus_1", 32'(ifa.resp_valid), 32'd0);
    step();
    chk("t1_valid_t_plus_2", 32'(ifa.resp_valid), 32'd1);
    chk("t1_data_t_plus_2", ifa.resp_data, 32'h0000_0013);
    step();

    // Back-pressure: third request stalls at QUEUE_DEPTH 2
    bd_write(wa(1), 32'h0000_0101);
    bd_write(wa(2), 32'h0000_0202);
    bd_write(wa(3), 32'h0000_0303);
    ifa.resp_ready = 1'b0;
    ifa.req_valid = 1'b1; ifa.req_data = wa(1);
    step();
    ifa.req_data = wa(2);
    step();
    ifa.req_data = wa(3);
    chk("t2_third_stalls", 32'(ifa.req_ready), 32'd0);
    chk("t2_head_valid", 32'(ifa.resp_valid), 32'd1);
    chk("t2_head_data", ifa.resp_data, 32'h0000_0101);
    step();
    chk("t2_still_stalled", 32'(ifa.req_ready), 32'd0);
    chk("t2_head_hold", ifa.resp_data, 32'h0000_0101);
    step();
    ifa.resp_ready = 1'b1;
    chk("t2_stall_in_fire_cycle", 32'(ifa.req_ready), 32'd0);
    step();
    chk("t2_ready_after_fire", 32'(ifa.req_ready), 32'd1);
    chk("t2_second_data", ifa.resp_data, 32'h0000_0202);
    step();
    ifa.req_valid = 1'b0;
    chk("t2_gap_before_third", 32'(ifa.resp_valid), 32'd0);
    step();
    chk("t2_third_valid", 32'(ifa.resp_valid), 32'd1);
    chk("t2_third_data", ifa.resp_data, 32'h0000_0303);
    step();

    // Streaming at QUEUE_DEPTH 3: ten responses on ten consecutive cycles
    for (int i = 0; i < 10; i++) bd_write(wa(16 + i), 32'h0000_1000 + 32'(i));
    nf = 0; first = -1; last = -1;
    for (int c = 0; c < 20; c++) begin
      if (c < 10) begin
        ifb.req_valid = 1'b1; ifb.req_data = wa(16 + c);
        chk("t3_req_ready", 32'(ifb.req_ready), 32'd1);
      end else begin
        ifb.req_valid = 1'b0;
      end
      if (ifb.resp_valid) begin
        chk("t3_stream_data", ifb.resp_data, 32'h0000_1000 + 32'(nf));
        if (first < 0) first = c;
        last = c;
        nf++;
      end
      step();
    end
    chk("t3_resp_count", 32'(nf), 32'd10);
    chk("t3_consecutive", 32'(last - first), 32'd9);
    chk("t3_first_latency", 32'(first), 32'd2);

    // Same-cycle backdoor write and read of word 5
    bd_write(wa(5), 32'hAAAA_0005);
    ifa.req_valid = 1'b1; ifa.req_data = wa(5);
    bd_we = 1'b1; bd_addr = wa(5); bd_data = 32'h5555_0005;
    step();
    bd_we = 1'b0;
    step();
    ifa.req_valid = 1'b0;
    wait_resp_a("t4_old_value", 32'hAAAA_0005);
    wait_resp_a("t4_new_value", 32'h5555_0005);

    // Reset one cycle after an accept discards the request
    ifa.req_valid = 1'b1; ifa.req_data = wa(1);
    step();
    ifa.req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_resp_valid_after_release", 32'(ifa.resp_valid), 32'd0);
    chk("t5_req_ready_after_release", 32'(ifa.req_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_no_stale_resp", 32'(ifa.resp_valid), 32'd0);
    end
    chk("t5_mem_kept", 32'(sh[1] == 32'h0000_0101), 32'd1);

    // Below-base, misaligned and past-end addresses
    bd_write(wa(WORDS - 1), 32'hCAFE_0FFF);
    t6_addr[0] = 32'h7FFF_FFFC;
    t6_addr[1] = 32'h8000_0016;
    t6_addr[2] = 32'h8000_4000;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
    t6_exp[0] = 32'hDEAD_BEEF; t6_exp[1] = 32'hDEAD_BEEF; t6_exp[2] = 32'hDEAD_BEEF;
`else
    t6_exp[0] = 32'hCAFE_0FFF; t6_exp[1] = 32'h5555_0005; t6_exp[2] = 32'h0000_0013;
`endif
    for (int i = 0; i < 3; i++) begin
      ifa.req_valid = 1'b1; ifa.req_data = t6_addr[i];
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
      chk("t6_bad_pulse", 32'(bad_a), 32'd1);
`endif
      step();
      ifa.req_valid = 1'b0;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
      chk("t6_bad_single_cycle", 32'(bad_a), 32'd0);
`endif
      wait_resp_a("t6_edge_addr", t6_exp[i]);
    end

    repeat (4) step();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
